jpeg_cone_eval_sched: RTL
=========================

# jpeg_cone_eval_sched

Round-robin scheduler that shares a single JPEG timing-cone datapath (6 inputs, 1 output, purely combinational) between up to NUM_REQ requesters. It accepts one input vector per grant and drives it onto the cone. It then waits a programmable number of settle cycles, samples the cone output, and returns the result bit tagged with the requester ID over a valid/ready response channel. It sits between the evaluation clients and the combinational cone instance.

## Interface
- NUM_REQ, 4: number of requesters (2..8)
- IN_W, 6: cone input width
- SETTLE_W, 3: width of settle-cycle count
- ID_W, $clog2(NUM_REQ): requester ID width
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester vector valid
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_vec  in  NUM_REQ*IN_W  requester i occupies bits [i*IN_W +: IN_W]
- settle_cycles  in  SETTLE_W  settle wait; 0 is treated as 1
- cone_in  out  IN_W  drives the cone inputs
- cone_out  in  1  cone output
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result accepted
- rsp_id  out  ID_W  requester index of the result
- rsp_bit  out  1  sampled cone output
- eval_cnt  out  16  completed-evaluation count (see Configuration)

## Operation
- FSM states:
  - IDLE: arbitrate.
  - SETTLE: cone_in stable, count down.
  - RESP: rsp_valid high.
- IDLE:
  - The winner is the first i with req_valid[i] = 1, scanning from rr_ptr upward with wrap-around.
  - req_ready is asserted only for the winner; it is combinational from state, rr_ptr and req_valid.
  - On handshake: latch req_vec slice into cone_in, latch i into rsp_id, load the counter with max(settle_cycles,1), go to SETTLE.
- SETTLE:
  - Decrement the counter each cycle.
  - When the counter is 1: rsp_bit <= cone_out, rsp_valid <= 1, go to RESP.
  - settle_cycles is sampled only at acceptance; later changes are ignored.
- RESP:
  - Hold rsp_valid, rsp_id and rsp_bit stable until rsp_ready.
  - On the handshake: rsp_valid <= 0, rr_ptr <= rsp_id+1 (mod NUM_REQ), go to IDLE.
- req_ready is 0 in SETTLE and RESP; no new vector is accepted until the response retires.
- cone_in holds the last vector after completion; it changes only on acceptance.
- Reset values:
  - state IDLE, rr_ptr 0, cone_in 0, rsp_valid 0, rsp_id 0, rsp_bit 0, counter 0, eval_cnt 0.
  - req_ready follows IDLE arbitration immediately after reset.
- Reset mid-operation: the evaluation is abandoned, no response is produced, and outputs return to the reset values on the next edge.

## Timing
- Request accepted at edge T: cone_in is valid from T.
- cone_out is sampled at edge T+S, where S = max(settle_cycles,1).
- rsp_valid is high from edge T+S.
- Minimum request-to-response latency is 1 cycle (S = 1); maximum is 2^SETTLE_W - 1 cycles.
- With rsp_ready held high, the response retires at edge T+S+1, giving back-to-back throughput of one evaluation per S+2 cycles.
- A requester that holds req_valid with no competition is re-granted the cycle after its response retires. Fairness is rotation from rsp_id+1.
- If rsp_ready is already high when rsp_valid rises, the handshake completes on the following edge.

## Configuration
- CONE_EVAL_COUNT_EN:
  - Defined: eval_cnt increments on every response handshake and saturates at 16'hFFFF; reset clears it.
  - Undefined: eval_cnt is tied to 0 and the counter logic is not built. The port is always present.

## Test plan
- Single request: req_valid = 4'b0001, req_vec[5:0] = 6'h2A, settle_cycles = 3, cone_out = 1 -> cone_in = 6'h2A at T; rsp_valid rises at T+3 with rsp_id = 0, rsp_bit = 1.
- Round robin: all four valid continuously, rsp_ready = 1 -> grant order 0,1,2,3,0; each grant occurs S+2 cycles after the previous one.
- Backpressure: rsp_ready = 0 for 5 cycles after rsp_valid -> rsp_id/rsp_bit are stable, req_ready = 0 throughout; retirement occurs on the first edge with rsp_ready = 1.
- settle_cycles = 0 -> behaves as 1; rsp_valid one cycle after acceptance.
- Reset mid-SETTLE: rst_n = 0 for 1 cycle at T+1 with S = 5 -> no response, cone_in = 0, rr_ptr = 0, state IDLE.
- With CONE_EVAL_COUNT_EN: 3 completed evaluations -> eval_cnt = 3. Without the macro, eval_cnt = 0.

Source files
------------

// File: rtl/jpeg_cone_eval_sched.sv
// Round-robin scheduler sharing one combinational timing cone among NUM_REQ requesters.
// Define CONE_EVAL_COUNT_EN to build the saturating completed-evaluation counter on eval_cnt.
module jpeg_cone_eval_sched #(
  parameter int NUM_REQ  = 4,
  parameter int IN_W     = 6,
  parameter int SETTLE_W = 3,
  parameter int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*IN_W-1:0] req_vec,
  input  logic [SETTLE_W-1:0]     settle_cycles,
  output logic [IN_W-1:0]         cone_in,
  input  logic                    cone_out,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    rsp_bit,
  output logic [15:0]             eval_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    RESP
  } state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rrPtr_q, rrPtr_d;
  logic [ID_W-1:0]     rspId_q, rspId_d;
  logic [IN_W-1:0]     coneIn_q, coneIn_d;
  logic                rspValid_q, rspValid_d;
  logic                rspBit_q, rspBit_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;

  logic [2*NUM_REQ-1:0] rotValid;
  logic                 winFound;
  logic [ID_W-1:0]      winIdx;
  logic [IN_W-1:0]      winVec;
  logic [ID_W-1:0]      rspIdNext;
  logic [SETTLE_W-1:0]  settleLoad;

  // Adds an offset to a requester index, wrapping at NUM_REQ (need not be a power of two).
  function automatic logic [ID_W-1:0] wrapIdx(input logic [ID_W-1:0] base,
                                               input int unsigned     offs);
    logic [ID_W:0] sum;
    sum = {1'b0, base} + (ID_W+1)'(offs);
    if (sum >= (ID_W+1)'(NUM_REQ)) begin
      sum = sum - (ID_W+1)'(NUM_REQ);
    end
    return sum[ID_W-1:0];
  endfunction

  // Rotate so bit 0 is rr pointer; scan high-to-low so the lowest rotated slot wins last.
  always_comb begin
    rotValid = {req_valid, req_valid} >> rrPtr_q;
    winFound = 1'b0;
    winIdx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rotValid[k]) begin
        winFound = 1'b1;
        winIdx   = wrapIdx(rrPtr_q, k);
      end
    end
  end

  always_comb begin
    winVec    = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winIdx == ID_W'(i)) begin
        winVec       = req_vec[i*IN_W +: IN_W];
        req_ready[i] = (state_q == IDLE) && winFound;
      end
    end
  end

  assign settleLoad = (settle_cycles == '0) ? SETTLE_W'(1) : settle_cycles;
  assign rspIdNext  = wrapIdx(rspId_q, 1);

  always_comb begin
    state_d    = state_q;
    rrPtr_d    = rrPtr_q;
    rspId_d    = rspId_q;
    coneIn_d   = coneIn_q;
    rspValid_d = rspValid_q;
    rspBit_d   = rspBit_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (winFound) begin
          coneIn_d = winVec;
          rspId_d  = winIdx;
          cnt_d    = settleLoad;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q - SETTLE_W'(1);
        if (cnt_q == SETTLE_W'(1)) begin
          rspBit_d   = cone_out;
          rspValid_d = 1'b1;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rspValid_d = 1'b0;
          rrPtr_d    = rspIdNext;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rrPtr_q    <= '0;
      rspId_q    <= '0;
      coneIn_q   <= '0;
      rspValid_q <= 1'b0;
      rspBit_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rrPtr_q    <= rrPtr_d;
      rspId_q    <= rspId_d;
      coneIn_q   <= coneIn_d;
      rspValid_q <= rspValid_d;
      rspBit_q   <= rspBit_d;
      cnt_q      <= cnt_d;
    end
  end

  assign cone_in   = coneIn_q;
  assign rsp_valid = rspValid_q;
  assign rsp_id    = rspId_q;
  assign rsp_bit   = rspBit_q;

`ifdef CONE_EVAL_COUNT_EN
  logic [15:0] evalCnt_q, evalCnt_d;

  // Counts retired responses, sticking at all-ones.
  always_comb begin
    evalCnt_d = evalCnt_q;
    if ((state_q == RESP) && rsp_ready && (evalCnt_q != 16'hFFFF)) begin
      evalCnt_d = evalCnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      evalCnt_q <= '0;
    end else begin
      evalCnt_q <= evalCnt_d;
    end
  end

  assign eval_cnt = evalCnt_q;
`else
  assign eval_cnt = 16'h0000;
`endif

endmodule
